q_sys_timer_sched: RTL and testbench

//  Sequencer that owns the 16-bit Avalon-MM slave port of the interval timer.

---
 rtl/q_sys_timer_pkg.sv | 39 +++
 rtl/q_sys_timer_sched.sv | 186 ++++++++++++++++++
 tb/tb_q_sys_timer_sched.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/q_sys_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : q_sys_timer_pkg
//  Purpose  : Interval-timer register map, control words and sequencer states.
//  Revision : 1.0 - initial release
// ============================================================================
package q_sys_timer_pkg;

  localparam logic [2:0] TMR_ADDR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_ADDR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_ADDR_PER_L   = 3'd2;
  localparam logic [2:0] TMR_ADDR_PER_H   = 3'd3;
  localparam logic [2:0] TMR_ADDR_SNAP_L  = 3'd4;
  localparam logic [2:0] TMR_ADDR_SNAP_H  = 3'd5;

  localparam int CTRL_ITO_BIT   = 0;
  localparam int CTRL_CONT_BIT  = 1;
  localparam int CTRL_START_BIT = 2;
  localparam int CTRL_STOP_BIT  = 3;

  localparam logic [3:0] CTRL_START = 4'h7;
  localparam logic [3:0] CTRL_STOP  = 4'h8;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_PL    = 4'd1,
    ST_WR_PH    = 4'd2,
    ST_WR_CTRL  = 4'd3,
    ST_RUN      = 4'd4,
    ST_ACK      = 4'd5,
    ST_STOP     = 4'd6,
    ST_SNAP_W   = 4'd7,
    ST_SNAP_RL  = 4'd8,
    ST_SNAP_RH  = 4'd9,
    ST_SNAP_CAP = 4'd10
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/q_sys_timer_sched.sv
`default_nettype none
// ============================================================================
//  Module   : q_sys_timer_sched
//  Purpose  : Sequences the interval timer's Avalon-MM port: program, run,
//             acknowledge/count timeouts, stop, and snapshot the counter.
//  Revision : 1.0 - initial release
// ============================================================================
module q_sys_timer_sched
  import q_sys_timer_pkg::*;
#(
  parameter int TICK_W     = 16,
  parameter int MIN_PERIOD = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_req,
  input  logic [31:0]       period,
  input  logic [TICK_W-1:0] tick_count,
  input  logic              stop_req,
  input  logic              snap_req,
  output logic              busy,
  output logic              tick,
  output logic [TICK_W-1:0] ticks_done,
  output logic              done,
  output logic              snap_valid,
  output logic [31:0]       snap_value,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic [15:0]       tmr_readdata,
  input  logic              tmr_irq
);

  localparam logic [31:0] c_min_period = 32'(MIN_PERIOD);

  sched_state_t      r_state;
  sched_state_t      w_next_state;
  logic [31:0]       r_period;
  logic [TICK_W-1:0] r_tick_count;
  logic [TICK_W-1:0] r_ticks_done;
  logic              r_busy;
  logic              r_done;
  logic              r_stop_pend;
  logic              r_snap_pend;
  logic              r_snap_from_run;
  logic [15:0]       r_snap_lo;
  logic [15:0]       r_snap_hi;

  logic              w_start_acc;
  logic              w_stop_now;
  logic              w_snap_now;
  logic [TICK_W-1:0] w_ticks_inc;
  logic [31:0]       w_period_clamped;

  assign w_start_acc      = (r_state == ST_IDLE) && start_req;
  assign w_stop_now       = stop_req || r_stop_pend;
  assign w_snap_now       = snap_req || r_snap_pend;
  assign w_ticks_inc      = r_ticks_done + 1'b1;
  assign w_period_clamped = (period < c_min_period) ? c_min_period : period;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start_req)       w_next_state = ST_WR_PL;
        else if (w_snap_now) w_next_state = ST_SNAP_W;
      end
      ST_WR_PL:   w_next_state = ST_WR_PH;
      ST_WR_PH:   w_next_state = ST_WR_CTRL;
      ST_WR_CTRL: w_next_state = ST_RUN;
      ST_RUN: begin
        if (w_stop_now)      w_next_state = ST_STOP;
        else if (tmr_irq)    w_next_state = ST_ACK;
        else if (w_snap_now) w_next_state = ST_SNAP_W;
      end
      ST_ACK: begin
        if ((r_tick_count != '0) && (w_ticks_inc == r_tick_count))
          w_next_state = ST_STOP;
        else
          w_next_state = ST_RUN;
      end
      ST_STOP:     w_next_state = ST_IDLE;
      ST_SNAP_W:   w_next_state = ST_SNAP_RL;
      ST_SNAP_RL:  w_next_state = ST_SNAP_RH;
      ST_SNAP_RH:  w_next_state = ST_SNAP_CAP;
      ST_SNAP_CAP: w_next_state = r_snap_from_run ? ST_RUN : ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period        <= '0;
      r_tick_count    <= '0;
      r_ticks_done    <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_stop_pend     <= 1'b0;
      r_snap_pend     <= 1'b0;
      r_snap_from_run <= 1'b0;
      r_snap_lo       <= '0;
      r_snap_hi       <= '0;
    end else begin
      if (w_start_acc) begin
        r_period     <= w_period_clamped;
        r_tick_count <= tick_count;
        r_ticks_done <= '0;
        r_busy       <= 1'b1;
      end
      if (r_state == ST_ACK)  r_ticks_done <= w_ticks_inc;
      if (r_state == ST_STOP) r_busy <= 1'b0;
      r_done <= (r_state == ST_STOP);

      // Stops that land while the bus is occupied are replayed in RUN.
      if (r_state inside {ST_IDLE, ST_RUN, ST_STOP}) r_stop_pend <= 1'b0;
      else if (stop_req)                             r_stop_pend <= 1'b1;

      if (w_next_state == ST_SNAP_W) begin
        r_snap_pend     <= 1'b0;
        r_snap_from_run <= (r_state == ST_RUN);
      end else if (snap_req) begin
        r_snap_pend <= 1'b1;
      end

      if (r_state == ST_SNAP_RH)  r_snap_lo <= tmr_readdata;
      if (r_state == ST_SNAP_CAP) r_snap_hi <= tmr_readdata;
    end
  end

  always_comb begin
    tmr_address    = TMR_ADDR_STATUS;
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_writedata  = '0;
    unique case (r_state)
      ST_WR_PL: begin
        tmr_address = TMR_ADDR_PER_L; tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_writedata = r_period[15:0];
      end
      ST_WR_PH: begin
        tmr_address = TMR_ADDR_PER_H; tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_writedata = r_period[31:16];
      end
      ST_WR_CTRL: begin
        tmr_address = TMR_ADDR_CONTROL; tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_writedata = {12'h000, CTRL_START};
      end
      ST_ACK: begin
        tmr_address = TMR_ADDR_STATUS; tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
      end
      ST_STOP: begin
        tmr_address = TMR_ADDR_CONTROL; tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        tmr_writedata = {12'h000, CTRL_STOP};
      end
      ST_SNAP_W: begin
        tmr_address = TMR_ADDR_SNAP_L; tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
      end
      ST_SNAP_RL: begin
        tmr_address = TMR_ADDR_SNAP_L; tmr_chipselect = 1'b1;
      end
      ST_SNAP_RH: begin
        tmr_address = TMR_ADDR_SNAP_H; tmr_chipselect = 1'b1;
      end
      default: begin
        tmr_address    = TMR_ADDR_STATUS;
        tmr_chipselect = 1'b0;
      end
    endcase
  end

  // The high half arrives on readdata during SNAP_CAP; present it with snap_valid.
  assign snap_value = {(r_state == ST_SNAP_CAP) ? tmr_readdata : r_snap_hi, r_snap_lo};
  assign snap_valid = (r_state == ST_SNAP_CAP);
  assign tick       = (r_state == ST_ACK);
  assign ticks_done = r_ticks_done;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_q_sys_timer_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_q_sys_timer_sched
//  Purpose  : Scoreboard bench for q_sys_timer_sched against a behavioural
//             interval-timer slave.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_q_sys_timer_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_req = 1'b0;
  logic [31:0] period = '0;
  logic [15:0] tick_count = '0;
  logic        stop_req = 1'b0;
  logic        snap_req = 1'b0;
  logic        busy, tick, done, snap_valid;
  logic [15:0] ticks_done;
  logic [31:0] snap_value;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect, tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;

  q_sys_timer_sched #(.TICK_W(16), .MIN_PERIOD(8)) dut (
    .clk(clk), .reset_n(reset_n), .start_req(start_req), .period(period),
    .tick_count(tick_count), .stop_req(stop_req), .snap_req(snap_req),
    .busy(busy), .tick(tick), .ticks_done(ticks_done), .done(done),
    .snap_valid(snap_valid), .snap_value(snap_value),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Interval timer slave: period+1 clocks per timeout, level irq until status write.
  logic [31:0] tm_per, tm_count, tm_snap;
  logic        tm_run, tm_to, tm_ito;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tm_per <= '0; tm_count <= '0; tm_snap <= '0;
      tm_run <= 1'b0; tm_to <= 1'b0; tm_ito <= 1'b0; tmr_readdata <= '0;
    end else begin
      if (tm_run) begin
        if (tm_count == 0) begin tm_to <= 1'b1; tm_count <= tm_per; end
        else tm_count <= tm_count - 1;
      end
      if (tmr_chipselect && !tmr_write_n) begin
        case (tmr_address)
          3'd0: tm_to <= 1'b0;
          3'd1: begin
            tm_ito <= tmr_writedata[0];
            if (tmr_writedata[2]) begin tm_run <= 1'b1; tm_count <= tm_per; end
            if (tmr_writedata[3]) tm_run <= 1'b0;
          end
          3'd2: tm_per[15:0]  <= tmr_writedata;
          3'd3: tm_per[31:16] <= tmr_writedata;
          3'd4: tm_snap <= tm_count;
          default: ;
        endcase
      end
      if (tmr_chipselect && tmr_write_n)
        tmr_readdata <= (tmr_address == 3'd4) ? tm_snap[15:0] :
                        (tmr_address == 3'd5) ? tm_snap[31:16] : 16'h0000;
    end
  end
  assign tmr_irq = tm_to && tm_ito;

  int n_tests = 0, n_fail = 0;
  int model_ticks = 0, done_cnt = 0, done_base = 0;
  int snap_valid_cnt = 0, snap_wr_cnt = 0, snaps_issued = 0, snap_cyc = 0;
  logic        tick_chk = 1'b0;
  logic [31:0] cur_period = '0;
  logic [18:0] exp_wr_q[$];
  logic [31:0] exp_snap_q[$];
  logic [2:0]  wr_log[$];
  int          tick_times[$];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  task automatic monitor_loop();
    logic [18:0] w;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (tick_chk) begin
          chk("ticks_done_step", 64'(ticks_done), 64'(model_ticks[15:0]));
          tick_chk = 1'b0;
        end
        if (tmr_chipselect && !tmr_write_n) begin
          wr_log.push_back(tmr_address);
          if (tmr_address == 3'd4) begin
            snap_wr_cnt++;
            exp_snap_q.push_back(tm_count);
          end else if (exp_wr_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL bus_write: got addr %0d data %h, expected no write", tmr_address, tmr_writedata);
          end else begin
            w = exp_wr_q.pop_front();
            chk("bus_write", 64'({tmr_address, tmr_writedata}), 64'(w));
          end
        end
        if (tick) begin
          model_ticks++;
          tick_times.push_back(cyc);
          tick_chk = 1'b1;
        end
        if (snap_valid) begin
          snap_valid_cnt++;
          snap_cyc = cyc;
          if (exp_snap_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL snap_valid: got pulse %0h, expected none outstanding", snap_value);
          end else begin
            e = exp_snap_q.pop_front();
            chk("snap_value", 64'(snap_value), 64'(e));
          end
          chk("snap_hi_zero", 64'(snap_value[31:16]), 0);
          chk("snap_le_period", 64'(snap_value <= cur_period), 1);
        end
        if (done) done_cnt++;
      end
    end
  endtask

  task automatic check_reset(string tg);
    chk({tg, "_busy"}, 64'(busy), 0);
    chk({tg, "_tick"}, 64'(tick), 0);
    chk({tg, "_done"}, 64'(done), 0);
    chk({tg, "_snap_valid"}, 64'(snap_valid), 0);
    chk({tg, "_ticks_done"}, 64'(ticks_done), 0);
    chk({tg, "_snap_value"}, 64'(snap_value), 0);
    chk({tg, "_bus"}, 64'({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}), 64'({1'b0, 1'b1, 3'd0, 16'h0}));
  endtask

  task automatic start_run(input logic [31:0] p, input logic [15:0] n, input int acks);
    logic [31:0] cp;
    int na;
    cp = (p < 32'd8) ? 32'd8 : p;
    na = (n != 0) ? int'(n) : acks;
    @(negedge clk);
    exp_wr_q.push_back({3'd2, cp[15:0]});
    exp_wr_q.push_back({3'd3, cp[31:16]});
    exp_wr_q.push_back({3'd1, 16'h0007});
    for (int i = 0; i < na; i++) exp_wr_q.push_back({3'd0, 16'h0000});
    if (n != 0) exp_wr_q.push_back({3'd1, 16'h0008});
    cur_period  = cp;
    model_ticks = 0;
    done_base   = done_cnt;
    start_req = 1'b1; period = p; tick_count = n;
    @(negedge clk);
    start_req = 1'b0;
    chk("busy_after_start", 64'(busy), 1);
  endtask

  task automatic stop_run();
    @(negedge clk);
    exp_wr_q.push_back({3'd1, 16'h0008});
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3000 && done_cnt == done_base; k++) @(posedge clk);
    chk("done_seen", 64'(done_cnt > done_base), 1);
    @(negedge clk);
    chk("busy_low_after_done", 64'(busy), 0);
    chk("wr_queue_drained", 64'(exp_wr_q.size()), 0);
  endtask

  task automatic pulse_snap();
    @(negedge clk);
    snaps_issued++;
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int ti0, sz0, sv0, req_cyc;
    logic [31:0] rp;
    logic [15:0] rn;
    fork monitor_loop(); join_none
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1 check_reset("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Fixed three-tick run, then tick spacing.
    ti0 = tick_times.size();
    start_run(32'd99, 16'd3, 0);
    wait_done();
    chk("s1_ticks_done", 64'(ticks_done), 3);
    if (tick_times.size() >= ti0 + 3) begin
      chk("s1_tick_gap1", 64'(tick_times[ti0+1] - tick_times[ti0]), 100);
      chk("s1_tick_gap2", 64'(tick_times[ti0+2] - tick_times[ti0+1]), 100);
    end else chk("s1_tick_count", 64'(tick_times.size() - ti0), 3);

    // Free-running, stop after the fifth tick.
    start_run(32'd49, 16'd0, 5);
    for (int k = 0; k < 1000 && model_ticks < 5; k++) @(posedge clk);
    stop_run();
    wait_done();
    repeat (150) @(posedge clk);
    chk("s2_no_tick_after_stop", 64'(model_ticks), 5);
    chk("s2_ticks_done", 64'(ticks_done), 5);

    // Snapshot during RUN.
    start_run(32'd999, 16'd0, 0);
    repeat (300) @(negedge clk);
    sv0 = snap_valid_cnt;
    req_cyc = cyc;
    snaps_issued++;
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    for (int k = 0; k < 50 && snap_valid_cnt == sv0; k++) @(posedge clk);
    chk("s3_snap_valid_seen", 64'(snap_valid_cnt), 64'(sv0 + 1));
    chk("s3_snap_latency", 64'(snap_cyc - req_cyc), 4);
    stop_run();
    wait_done();

    // irq and snap_req in the same cycle: ACK first, then snapshot.
    start_run(32'd199, 16'd0, 1);
    for (int k = 0; k < 1000 && !tmr_irq; k++) @(negedge clk);
    sz0 = wr_log.size();
    sv0 = snap_valid_cnt;
    snaps_issued++;
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    for (int k = 0; k < 50 && snap_valid_cnt == sv0; k++) @(posedge clk);
    chk("s4_snap_valid_seen", 64'(snap_valid_cnt), 64'(sv0 + 1));
    chk("s4_one_tick", 64'(model_ticks), 1);
    chk("s4_order_len", 64'(wr_log.size() >= sz0 + 2), 1);
    if (wr_log.size() >= sz0 + 2) begin
      chk("s4_first_write_ack", 64'(wr_log[sz0]), 0);
      chk("s4_then_snap_write", 64'(wr_log[sz0+1]), 4);
    end
    stop_run();
    wait_done();

    // Clamped period; start_req while busy has no effect.
    start_run(32'd3, 16'd2, 0);
    start_req = 1'b1; period = 32'd500; tick_count = 16'd7;
    @(negedge clk);
    start_req = 1'b0;
    repeat (6) @(negedge clk);
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    wait_done();
    chk("s5_ticks_done", 64'(ticks_done), 2);

    // Randomised runs with an occasional snapshot.
    for (int it = 0; it < 8; it++) begin
      rp = 32'($urandom_range(0, 40));
      rn = 16'($urandom_range(1, 3));
      start_run(rp, rn, 0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3 * (int'(cur_period) + 1))) @(negedge clk);
        pulse_snap();
      end
      wait_done();
      repeat (12) @(negedge clk);
      chk("rnd_ticks_done", 64'(ticks_done), 64'(rn));
      chk("rnd_snap_valid_count", 64'(snap_valid_cnt), 64'(snaps_issued));
      chk("rnd_snap_write_count", 64'(snap_wr_cnt), 64'(snaps_issued));
    end

    // Reset in the middle of a run.
    start_run(32'd99, 16'd0, 1);
    for (int k = 0; k < 1000 && model_ticks < 1; k++) @(posedge clk);
    repeat (10) @(negedge clk);
    chk("s6_ticks_before_reset", 64'(ticks_done), 1);
    reset_n = 1'b0;
    #1 check_reset("midrun_reset");
    exp_wr_q.delete();
    exp_snap_q.delete();
    model_ticks = 0;
    tick_chk = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    start_run(32'd20, 16'd1, 0);
    wait_done();
    chk("s6_ticks_after_reset", 64'(ticks_done), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
